// File: rtl/bcd_2_dec_decoder.sv
// -----------------------------------------------------------------------------
// bcd_2_dec_decoder
//   Registered BCD-to-decimal (1-of-10) decoder. The 4-bit code {a,b,c,d}
//   (a = MSB) is sampled on every rising clk edge. One cycle later the code
//   appears as a one-hot 10-bit word on y. Codes 10..15 are not valid BCD:
//   for those, y is all zero and err is raised.
//
//   Optional feature: define BCD_2_DEC_ERRCNT_EN to add err_cnt. This is a
//   saturating counter of sampled invalid codes, and only rst_n clears it.
//
// Ports
//   clk      in   1          rising-edge clock
//   rst_n    in   1          asynchronous active-low reset
//   a,b,c,d  in   1 each     BCD digit, a = weight 8 ... d = weight 1
//   y        out  10         one-hot decimal output, y[n]=1 <=> code==n
//   err      out  1          registered code is 10..15
//   err_cnt  out  ERR_CNT_W  (BCD_2_DEC_ERRCNT_EN only) invalid-code count
//
// Interface timing: this block has no handshake. y, err and err_cnt are
// always valid, and each reflects the inputs sampled at the previous rising
// edge. While rst_n is low, all outputs are held at zero.
// -----------------------------------------------------------------------------
module bcd_2_dec_decoder #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a,
  input  logic                 b,
  input  logic                 c,
  input  logic                 d,
  output logic [9:0]           y,
  output logic                 err
`ifdef BCD_2_DEC_ERRCNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  // Reject an unusable counter width at elaboration time.
  if (ERR_CNT_W < 1) begin : g_bad_width
    $error("bcd_2_dec_decoder: ERR_CNT_W must be >= 1");
  end

  logic [3:0] w_code;
  logic [9:0] w_y_next;
  logic       w_err_next;

  logic [9:0] r_y;
  logic       r_err;

  assign w_code = {a, b, c, d};

  // Full case: any code that is not a decimal digit falls through to the
  // all-zero / error result, so y can never carry more than one set bit.
  always_comb begin
    w_y_next   = 10'b0;
    w_err_next = 1'b0;
    case (w_code)
      4'd0:    w_y_next = 10'b00_0000_0001;
      4'd1:    w_y_next = 10'b00_0000_0010;
      4'd2:    w_y_next = 10'b00_0000_0100;
      4'd3:    w_y_next = 10'b00_0000_1000;
      4'd4:    w_y_next = 10'b00_0001_0000;
      4'd5:    w_y_next = 10'b00_0010_0000;
      4'd6:    w_y_next = 10'b00_0100_0000;
      4'd7:    w_y_next = 10'b00_1000_0000;
      4'd8:    w_y_next = 10'b01_0000_0000;
      4'd9:    w_y_next = 10'b10_0000_0000;
      default: w_err_next = 1'b1;
    endcase
  end

  // Registering y and err here is what prevents input glitches between
  // edges from reaching the display drivers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y   <= 10'b0;
      r_err <= 1'b0;
    end else begin
      r_y   <= w_y_next;
      r_err <= w_err_next;
    end
  end

  assign y   = r_y;
  assign err = r_err;

`ifdef BCD_2_DEC_ERRCNT_EN
  logic [ERR_CNT_W-1:0] r_err_cnt;

  // Once the counter reaches all-ones it stops, so it never wraps to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (w_err_next && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_bcd_2_dec_decoder.sv
// -----------------------------------------------------------------------------
// tb_bcd_2_dec_decoder
//   Drives BCD codes, pushes the expected registered response at each sampling
//   edge, and lets an independent monitor pop and compare on every falling
//   edge. Asynchronous-reset and glitch behaviour are checked in-line.
// -----------------------------------------------------------------------------
module tb_bcd_2_dec_decoder;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [9:0]       y;
    logic             err;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
  logic [9:0] y;
  logic       err;
`ifdef BCD_2_DEC_ERRCNT_EN
  logic [CNT_W-1:0] err_cnt;
`endif

  always #5 clk = ~clk;

  bcd_2_dec_decoder #(.ERR_CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .y     (y),
    .err   (err)
`ifdef BCD_2_DEC_ERRCNT_EN
    ,
    .err_cnt (err_cnt)
`endif
  );

  // scoreboard state
  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   model_errs = 0;   // invalid codes sampled since last reset

  // reference model: digit n lights lamp n; anything above 9 lights nothing
  function automatic exp_t model(input int code);
    exp_t e;
    e.y   = 10'b0;
    e.err = 1'b0;
    if (code <= 9) e.y[code] = 1'b1;
    else           e.err     = 1'b1;
    e.cnt = CNT_W'((model_errs > CNT_MAX) ? CNT_MAX : model_errs);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_zero(input string name);
    check({name, "_y"}, 32'(y), 32'd0);
    check({name, "_err"}, 32'(err), 32'd0);
`ifdef BCD_2_DEC_ERRCNT_EN
    check({name, "_cnt"}, 32'(err_cnt), 32'd0);
`endif
  endtask

  function automatic int cur_code();
    return int'({a, b, c, d});
  endfunction

  // driver: called just after a falling edge; returns at the next falling edge
  task automatic drive_code(input int code);
    {a, b, c, d} = 4'(code);
    @(posedge clk);
    if (code > 9) model_errs++;
    exp_q.push_back(model(code));
    @(negedge clk);
  endtask

  // monitor: decoupled from the driver, compares whatever is pending
  always @(negedge clk) begin
    if (rst_n) check("onehot", 32'($countones(y) <= 1), 32'd1);
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("y", 32'(y), 32'(e.y));
      check("err", 32'(err), 32'(e.err));
`ifdef BCD_2_DEC_ERRCNT_EN
      check("err_cnt", 32'(err_cnt), 32'(e.cnt));
`endif
    end
  end

  initial begin
    exp_t g;
    // 1: reset held with 0101 applied
    {a, b, c, d} = 4'b0101;
    #1 check_zero("rst_imm");
    repeat (3) begin
      @(negedge clk);
      check_zero("rst_hold");
    end
    rst_n = 1'b1;
    drive_code(5);

    // 2: sweep of all digits
    for (int i = 0; i < 10; i++) drive_code(i);

    // 3: every invalid code
    for (int i = 10; i < 16; i++) drive_code(i);

    // random mix, including repeats (hold) and saturation
    for (int i = 0; i < 60; i++) drive_code(int'($urandom_range(0, 15)));

    // 4: async reset mid-stream, discarding the pending 0111
    drive_code(3);
    {a, b, c, d} = 4'b0111;
    #2 rst_n = 1'b0;
    model_errs = 0;
    #1 check_zero("async_rst");
    @(posedge clk);
    #1 check_zero("rst_edge");
    @(negedge clk);
    rst_n = 1'b1;

    // 5: saturation from a clean count
    for (int i = 0; i < 5; i++) drive_code(int'($urandom_range(10, 15)));
    drive_code(2);

    // 6: glitches between edges must not disturb y
    for (int k = 0; k < 6; k++) begin
      int code;
      code = int'($urandom_range(0, 15));
      {a, b, c, d} = 4'(code);
      @(posedge clk);
      if (code > 9) model_errs++;
      g = model(code);
      exp_q.push_back(g);
      for (int j = 0; j < 3; j++) begin
        #1 {a, b, c, d} = 4'($urandom_range(0, 15));
        #0 check("glitch_y", 32'(y), 32'(g.y));
        check("glitch_err", 32'(err), 32'(g.err));
      end
      @(negedge clk);
    end
    drive_code(cur_code());

    // drain with a bounded wait
    for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
